// File: rtl/apb_arb_pkg.sv
// Shared types, slot map and address decode for the APB round-robin arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DERR   = 2'd3
    } state_e;

    localparam logic [31:0] SLOT0_BASE  = 32'h8000_0000;
    localparam logic [31:0] SLOT0_LIMIT = 32'h83FF_FFFF;
    localparam logic [31:0] SLOT1_BASE  = 32'h8400_0000;
    localparam logic [31:0] SLOT1_LIMIT = 32'h87FF_FFFF;
    localparam logic [31:0] SLOT2_BASE  = 32'h8800_0000;
    localparam logic [31:0] SLOT2_LIMIT = 32'h8BFF_FFFF;

    localparam logic [2:0] SEL_NONE  = 3'b000;
    localparam logic [2:0] SEL_SLOT0 = 3'b001;
    localparam logic [2:0] SEL_SLOT1 = 3'b010;
    localparam logic [2:0] SEL_SLOT2 = 3'b100;

    // Returns the one-hot Pselx code for an address; SEL_NONE means no slave claims it.
    function automatic logic [2:0] decode_slot(input logic [31:0] addr);
        logic [2:0] sel;
        sel = SEL_NONE;
        if (addr >= SLOT0_BASE && addr <= SLOT0_LIMIT) begin
            sel = SEL_SLOT0;
        end else if (addr >= SLOT1_BASE && addr <= SLOT1_LIMIT) begin
            sel = SEL_SLOT1;
        end else if (addr >= SLOT2_BASE && addr <= SLOT2_LIMIT) begin
            sel = SEL_SLOT2;
        end
        return sel;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int unsigned PW = $clog2(NREQ);

    logic        found;
    logic [31:0] cand;

    // Scan NREQ candidates starting at ptr; the first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (32'(ptr) + i) % NREQ;
            if (!found && req[cand[PW-1:0]]) begin
                found = 1'b1;
                idx   = cand[PW-1:0];
            end
        end
        if (found) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master port among NREQ requesters.
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned TMO  = 15
) (
    input  logic               Hclk,
    input  logic               Hresetn,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    wr_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ*DW-1:0] wdata_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    done_o,
    output logic               err_o,
    output logic [DW-1:0]      rdata_o,
    output logic [2:0]         Pselx,
    output logic               Penable,
    output logic               Pwrite,
    output logic [AW-1:0]      Paddr,
    output logic [DW-1:0]      Pwdata,
    input  logic [DW-1:0]      Prdata,
    input  logic               Pready,
    input  logic               Pslverr
);

    localparam int unsigned PW = $clog2(NREQ);
    // TMO = 0 would give a zero-width counter; keep one bit that never moves.
    localparam int unsigned CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(TMO);
    localparam logic [CW-1:0] CNT_ABORT = CW'(TMO - 1);

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [2:0]      psel_q, psel_d;
    logic            penable_q, penable_d;
    logic            pwrite_q, pwrite_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic [2:0]      pick_sel;
    logic            done_c, err_c;
    logic [DW-1:0]   rdata_c;

    logic [AW-1:0] addr_arr  [NREQ];
    logic [DW-1:0] wdata_arr [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign addr_arr[k]  = addr_i[k*AW +: AW];
        assign wdata_arr[k] = wdata_i[k*DW +: DW];
    end

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req (req_i),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign pick_sel = decode_slot(32'(addr_arr[pick_idx]));

    // Next-state, command latch and completion signalling.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        cnt_d     = cnt_q;
        done_c    = 1'b0;
        err_c     = 1'b0;
        rdata_c   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    gnt_d    = pick_gnt;
                    ptr_d    = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
                    pwrite_d = wr_i[pick_idx];
                    paddr_d  = addr_arr[pick_idx];
                    pwdata_d = wdata_arr[pick_idx];
                    if (pick_sel != SEL_NONE) begin
                        psel_d  = pick_sel;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_DERR;
                    end
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (Pready) begin
                    done_c  = 1'b1;
                    err_c   = Pslverr;
                    rdata_c = Prdata;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    // Abort in the cycle the count reaches TMO.
                    if (TMO != 0 && cnt_q == CNT_ABORT) begin
                        done_c = 1'b1;
                        err_c  = 1'b1;
                    end
                end
                if (done_c) begin
                    psel_d    = SEL_NONE;
                    penable_d = 1'b0;
                    gnt_d     = '0;
                    state_d   = ST_IDLE;
                end
            end
            ST_DERR: begin
                done_c  = 1'b1;
                err_c   = 1'b1;
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and APB output registers with synchronous active-low reset.
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            psel_q    <= SEL_NONE;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            cnt_q     <= cnt_d;
        end
    end

    // A reset edge aborts the transfer, so completion is suppressed while reset is low.
    assign done_o  = (Hresetn && done_c) ? gnt_q : '0;
    assign err_o   = Hresetn & err_c;
    assign rdata_o = Hresetn ? rdata_c : '0;

    assign gnt_o   = gnt_q;
    assign Pselx   = psel_q;
    assign Penable = penable_q;
    assign Pwrite  = pwrite_q;
    assign Paddr   = paddr_q;
    assign Pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: per-cycle vector table plus corner-case sequences.
module tb_apb_rr_arbiter;

    logic         Hclk;
    logic         Hresetn;
    logic [3:0]   req_i;
    logic [3:0]   wr_i;
    logic [127:0] addr_i;
    logic [127:0] wdata_i;
    logic [3:0]   gnt_o;
    logic [3:0]   done_o;
    logic         err_o;
    logic [31:0]  rdata_o;
    logic [2:0]   Pselx;
    logic         Penable;
    logic         Pwrite;
    logic [31:0]  Paddr;
    logic [31:0]  Pwdata;
    logic [31:0]  Prdata;
    logic         Pready;
    logic         Pslverr;

    int n_cmp  = 0;
    int n_fail = 0;

    apb_rr_arbiter #(
        .NREQ (4),
        .AW   (32),
        .DW   (32),
        .TMO  (15)
    ) dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .req_i   (req_i),
        .wr_i    (wr_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .gnt_o   (gnt_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .rdata_o (rdata_o),
        .Pselx   (Pselx),
        .Penable (Penable),
        .Pwrite  (Pwrite),
        .Paddr   (Paddr),
        .Pwdata  (Pwdata),
        .Prdata  (Prdata),
        .Pready  (Pready),
        .Pslverr (Pslverr)
    );

    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    typedef struct {
        logic [3:0] req;
        logic       pready;
        logic       pslverr;
        logic [2:0] psel;
        logic       pen;
        logic [3:0] gnt;
        logic [3:0] done;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    task automatic set_cmd(input int k, input logic w, input logic [31:0] a,
                           input logic [31:0] d);
        wr_i[k]            = w;
        addr_i[k*32 +: 32]  = a;
        wdata_i[k*32 +: 32] = d;
    endtask

    task automatic add(input logic [3:0] req, input logic pr, input logic se,
                       input logic [2:0] ps, input logic pe, input logic [3:0] g,
                       input logic [3:0] dn, input logic er);
        vec_t v;
        v.req = req; v.pready = pr; v.pslverr = se; v.psel = ps;
        v.pen = pe; v.gnt = g; v.done = dn; v.err = er;
        tbl.push_back(v);
    endtask

    initial begin
        Hresetn = 1'b0;
        req_i   = '0;
        wr_i    = '0;
        addr_i  = '0;
        wdata_i = '0;
        Prdata  = 32'hDEAD_BEEF;
        Pready  = 1'b0;
        Pslverr = 1'b0;
        set_cmd(0, 1'b1, 32'h8000_0010, 32'hA5A5_A5A5);
        set_cmd(1, 1'b1, 32'h8400_0020, 32'h1111_1111);
        set_cmd(2, 1'b1, 32'h8800_0030, 32'h2222_2222);
        set_cmd(3, 1'b1, 32'h8000_0040, 32'h3333_3333);

        // All four held, zero wait states: grants 0,1,2,3,0 (req2 answers with Pslverr).
        add(4'b1111, 1, 0, 3'b000, 0, 4'b0000, 4'b0000, 0);
        add(4'b1111, 1, 0, 3'b001, 0, 4'b0001, 4'b0000, 0);
        add(4'b1111, 1, 0, 3'b001, 1, 4'b0001, 4'b0001, 0);
        add(4'b1111, 1, 0, 3'b000, 0, 4'b0000, 4'b0000, 0);
        add(4'b1111, 1, 0, 3'b010, 0, 4'b0010, 4'b0000, 0);
        add(4'b1111, 1, 0, 3'b010, 1, 4'b0010, 4'b0010, 0);
        add(4'b1111, 1, 0, 3'b000, 0, 4'b0000, 4'b0000, 0);
        add(4'b1111, 1, 0, 3'b100, 0, 4'b0100, 4'b0000, 0);
        add(4'b1111, 1, 1, 3'b100, 1, 4'b0100, 4'b0100, 1);
        add(4'b1111, 1, 0, 3'b000, 0, 4'b0000, 4'b0000, 0);
        add(4'b1111, 1, 0, 3'b001, 0, 4'b1000, 4'b0000, 0);
        add(4'b1111, 1, 0, 3'b001, 1, 4'b1000, 4'b1000, 0);
        add(4'b1111, 1, 0, 3'b000, 0, 4'b0000, 4'b0000, 0);
        add(4'b1111, 1, 0, 3'b001, 0, 4'b0001, 4'b0000, 0);
        add(4'b1111, 1, 0, 3'b001, 1, 4'b0001, 4'b0001, 0);
        add(4'b0000, 1, 0, 3'b000, 0, 4'b0000, 4'b0000, 0);
        // Single write from req0 alone.
        add(4'b0001, 1, 0, 3'b000, 0, 4'b0000, 4'b0000, 0);
        add(4'b0001, 1, 0, 3'b001, 0, 4'b0001, 4'b0000, 0);
        add(4'b0001, 1, 0, 3'b001, 1, 4'b0001, 4'b0001, 0);
        add(4'b0000, 1, 0, 3'b000, 0, 4'b0000, 4'b0000, 0);

        // Reset state.
        repeat (3) @(posedge Hclk);
        #1;
        Pready = 1'b1;
        #1;
        chk("rst_psel", 64'(Pselx), 64'h0);
        chk("rst_pen", 64'(Penable), 64'h0);
        chk("rst_gnt", 64'(gnt_o), 64'h0);
        chk("rst_done", 64'(done_o), 64'h0);
        chk("rst_paddr", 64'(Paddr), 64'h0);
        chk("rst_pwdata", 64'(Pwdata), 64'h0);
        chk("rst_pwrite", 64'(Pwrite), 64'h0);
        step();
        Hresetn = 1'b1;

        for (int r = 0; r < tbl.size(); r++) begin
            req_i   = tbl[r].req;
            Pready  = tbl[r].pready;
            Pslverr = tbl[r].pslverr;
            #1;
            chk($sformatf("v%0d_psel", r), 64'(Pselx), 64'(tbl[r].psel));
            chk($sformatf("v%0d_pen", r), 64'(Penable), 64'(tbl[r].pen));
            chk($sformatf("v%0d_gnt", r), 64'(gnt_o), 64'(tbl[r].gnt));
            chk($sformatf("v%0d_done", r), 64'(done_o), 64'(tbl[r].done));
            chk($sformatf("v%0d_err", r), 64'(err_o), 64'(tbl[r].err));
            step();
        end
        Pslverr = 1'b0;
        chk("wr_paddr", 64'(Paddr), 64'h8000_0010);
        chk("wr_pwdata", 64'(Pwdata), 64'hA5A5_A5A5);
        chk("wr_pwrite", 64'(Pwrite), 64'h1);

        // Read from req2 with three wait states; payload changed after grant.
        set_cmd(2, 1'b0, 32'h8400_0004, 32'h0);
        Prdata = 32'h1234_5678;
        Pready = 1'b0;
        req_i  = 4'b0100;
        step(); #1;
        chk("rd_setup_psel", 64'(Pselx), 64'h2);
        chk("rd_setup_pen", 64'(Penable), 64'h0);
        chk("rd_setup_paddr", 64'(Paddr), 64'h8400_0004);
        chk("rd_setup_pwrite", 64'(Pwrite), 64'h0);
        chk("rd_setup_gnt", 64'(gnt_o), 64'h4);
        set_cmd(2, 1'b1, 32'h8800_0000, 32'hFFFF_FFFF);
        for (int w = 0; w < 3; w++) begin
            step(); #1;
            chk($sformatf("rd_wait%0d_pen", w), 64'(Penable), 64'h1);
            chk($sformatf("rd_wait%0d_done", w), 64'(done_o), 64'h0);
            chk($sformatf("rd_wait%0d_paddr", w), 64'(Paddr), 64'h8400_0004);
        end
        step();
        Pready = 1'b1;
        #1;
        chk("rd_psel", 64'(Pselx), 64'h2);
        chk("rd_pen", 64'(Penable), 64'h1);
        chk("rd_done", 64'(done_o), 64'h4);
        chk("rd_err", 64'(err_o), 64'h0);
        chk("rd_rdata", 64'(rdata_o), 64'h1234_5678);
        req_i = 4'b0000;
        step(); #1;
        chk("rd_end_psel", 64'(Pselx), 64'h0);
        chk("rd_end_gnt", 64'(gnt_o), 64'h0);

        // Decode miss from req1.
        set_cmd(1, 1'b1, 32'h9000_0000, 32'h5555_5555);
        req_i = 4'b0010;
        step(); #1;
        chk("miss_psel", 64'(Pselx), 64'h0);
        chk("miss_pen", 64'(Penable), 64'h0);
        chk("miss_gnt", 64'(gnt_o), 64'h2);
        chk("miss_done", 64'(done_o), 64'h2);
        chk("miss_err", 64'(err_o), 64'h1);
        req_i = 4'b0000;
        step(); #1;
        chk("miss_end_done", 64'(done_o), 64'h0);
        chk("miss_end_gnt", 64'(gnt_o), 64'h0);

        // Timeout on req3 with req0 waiting; ptr is 2 here so req3 wins.
        set_cmd(3, 1'b1, 32'h8800_0008, 32'h7777_7777);
        Pready = 1'b0;
        req_i  = 4'b1001;
        step(); #1;
        chk("tmo_setup_gnt", 64'(gnt_o), 64'h8);
        chk("tmo_setup_psel", 64'(Pselx), 64'h4);
        for (int k = 1; k <= 15; k++) begin
            step(); #1;
            chk($sformatf("tmo_c%0d_done", k), 64'(done_o), (k == 15) ? 64'h8 : 64'h0);
            if (k == 15) begin
                chk("tmo_err", 64'(err_o), 64'h1);
                chk("tmo_rdata", 64'(rdata_o), 64'h0);
                chk("tmo_pen", 64'(Penable), 64'h1);
            end
        end
        req_i = 4'b0001;
        step(); #1;
        chk("tmo_end_psel", 64'(Pselx), 64'h0);
        chk("tmo_end_pen", 64'(Penable), 64'h0);
        chk("tmo_end_gnt", 64'(gnt_o), 64'h0);
        step(); #1;
        chk("tmo_next_gnt", 64'(gnt_o), 64'h1);
        chk("tmo_next_psel", 64'(Pselx), 64'h1);

        // Reset in ACCESS: completion suppressed, everything clears, ptr back to 0.
        step(); #1;
        chk("rmid_pen", 64'(Penable), 64'h1);
        Pready  = 1'b1;
        Hresetn = 1'b0;
        #1;
        chk("rmid_done", 64'(done_o), 64'h0);
        chk("rmid_err", 64'(err_o), 64'h0);
        chk("rmid_rdata", 64'(rdata_o), 64'h0);
        step(); #1;
        chk("rmid_psel", 64'(Pselx), 64'h0);
        chk("rmid_pen2", 64'(Penable), 64'h0);
        chk("rmid_gnt", 64'(gnt_o), 64'h0);
        chk("rmid_paddr", 64'(Paddr), 64'h0);
        chk("rmid_pwdata", 64'(Pwdata), 64'h0);
        Hresetn = 1'b1;
        req_i   = 4'b1111;
        step(); #1;
        chk("rmid_ptr_gnt", 64'(gnt_o), 64'h1);
        step(); #1;
        chk("rmid_after_done", 64'(done_o), 64'h1);
        req_i = 4'b0000;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
